axi_lite_mst: RTL

//  AXI-lite initiator (master) for the LSU/IFU-to-memory path: turns one core-side request into one
//  AXI-lite read (AR/R) or write (AW/W/B) transaction toward an AXI-lite responder such as the data SRAM.
//  One outstanding transaction; result returned on a valid/ready response port. Sits between LSU and bus/xbar.

---
 rtl/axi_lite_pkg.sv | 27 ++
 rtl/axi_lite_mst_if.sv | 39 +++
 rtl/axi_lite_mst_wr_track.sv | 55 +++++
 rtl/axi_lite_mst.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - AXI-lite initiator shared types, widths and response codes
package axi_lite_pkg;

    localparam int AXI_AW = 32;
    localparam int AXI_DW = 32;
    localparam int AXI_SW = AXI_DW / 8;
    localparam int AXI_RW = 2;

    localparam logic [AXI_RW-1:0] RESP_OKAY   = 2'b00;
    localparam logic [AXI_RW-1:0] RESP_EXOKAY = 2'b01;
    localparam logic [AXI_RW-1:0] RESP_SLVERR = 2'b10;
    localparam logic [AXI_RW-1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR,
        ST_WR_RESP,
        ST_RSP
    } mst_state_e;

    function automatic logic resp_is_err(input logic [AXI_RW-1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/axi_lite_mst_if.sv
// rtl/axi_lite_mst_if.sv - AXI-lite AR/R/AW/W/B channel bundle with master/slave views
interface axi_lite_mst_if;
    import axi_lite_pkg::*;

    logic [AXI_AW-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [AXI_DW-1:0] rdata;
    logic [AXI_RW-1:0] rresp;
    logic              rvalid;
    logic              rready;
    logic [AXI_AW-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [AXI_DW-1:0] wdata;
    logic [AXI_SW-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [AXI_RW-1:0] bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output araddr, arvalid, input arready,
        input rdata, rresp, rvalid, output rready,
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready
    );

    modport slave (
        input araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready,
        input awaddr, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready
    );

endinterface

// File: rtl/axi_lite_mst_wr_track.sv
// rtl/axi_lite_mst_wr_track.sv - independent AW/W valid and completion tracking for one write
module axi_lite_mst_wr_track (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_abort,
    input  logic i_awready,
    input  logic i_wready,
    output logic o_awvalid,
    output logic o_wvalid,
    output logic o_both_done
);

    logic r_awvalid;
    logic r_wvalid;
    logic r_aw_done;
    logic r_w_done;
    logic w_aw_hs;
    logic w_w_hs;

    assign w_aw_hs = r_awvalid && i_awready;
    assign w_w_hs  = r_wvalid && i_wready;

    // Include this cycle's handshakes so a same-cycle AW+W finish costs no extra cycle.
    assign o_both_done = (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);
    assign o_awvalid   = r_awvalid;
    assign o_wvalid    = r_wvalid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else if (i_start) begin
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else if (i_abort) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_awvalid <= 1'b0;
                r_aw_done <= 1'b1;
            end
            if (w_w_hs) begin
                r_wvalid <= 1'b0;
                r_w_done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_lite_mst.sv
// rtl/axi_lite_mst.sv - single-outstanding AXI-lite initiator for core load/store requests
// Optional abort of stuck transactions when AXI_MST_TIMEOUT_EN is defined.
module axi_lite_mst
    import axi_lite_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_wen,
    input  logic [AXI_AW-1:0] i_req_addr,
    input  logic [AXI_DW-1:0] i_req_wdata,
    input  logic [AXI_SW-1:0] i_req_wstrb,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [AXI_DW-1:0] o_rsp_rdata,
    output logic              o_rsp_err,
    axi_lite_mst_if.master    m_axi
);

    mst_state_e        r_state,     w_state_nxt;
    logic [AXI_AW-1:0] r_araddr,    w_araddr_nxt;
    logic              r_arvalid,   w_arvalid_nxt;
    logic              r_rready,    w_rready_nxt;
    logic [AXI_AW-1:0] r_awaddr,    w_awaddr_nxt;
    logic [AXI_DW-1:0] r_wdata,     w_wdata_nxt;
    logic [AXI_SW-1:0] r_wstrb,     w_wstrb_nxt;
    logic              r_bready,    w_bready_nxt;
    logic              r_rsp_valid, w_rsp_valid_nxt;
    logic [AXI_DW-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
    logic              r_rsp_err,   w_rsp_err_nxt;

    logic w_accept;
    logic w_busy;
    logic w_wr_start;
    logic w_abort;
    logic w_both_done;
    logic w_awvalid;
    logic w_wvalid;
    logic w_timeout;

    assign o_req_ready = !rst && (r_state == ST_IDLE);
    assign w_accept    = i_req_valid && o_req_ready;
    assign w_busy      = (r_state == ST_RD_ADDR) || (r_state == ST_RD_DATA) ||
                         (r_state == ST_WR)      || (r_state == ST_WR_RESP);

`ifdef AXI_MST_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_busy) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    // Fires on the edge where the count would reach TIMEOUT_CYC busy cycles.
    assign w_timeout = w_busy && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_araddr    <= '0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_awaddr    <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_bready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_araddr    <= w_araddr_nxt;
            r_arvalid   <= w_arvalid_nxt;
            r_rready    <= w_rready_nxt;
            r_awaddr    <= w_awaddr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_wstrb     <= w_wstrb_nxt;
            r_bready    <= w_bready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_araddr_nxt    = r_araddr;
        w_arvalid_nxt   = r_arvalid;
        w_rready_nxt    = r_rready;
        w_awaddr_nxt    = r_awaddr;
        w_wdata_nxt     = r_wdata;
        w_wstrb_nxt     = r_wstrb;
        w_bready_nxt    = r_bready;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;
        w_wr_start      = 1'b0;
        w_abort         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (i_req_wen) begin
                        w_awaddr_nxt = i_req_addr;
                        w_wdata_nxt  = i_req_wdata;
                        w_wstrb_nxt  = i_req_wstrb;
                        w_wr_start   = 1'b1;
                        w_state_nxt  = ST_WR;
                    end else begin
                        w_araddr_nxt  = i_req_addr;
                        w_arvalid_nxt = 1'b1;
                        w_state_nxt   = ST_RD_ADDR;
                    end
                end
            end
            ST_RD_ADDR: begin
                if (r_arvalid && m_axi.arready) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_state_nxt   = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (m_axi.rvalid && r_rready) begin
                    w_rsp_rdata_nxt = m_axi.rdata;
                    w_rsp_err_nxt   = resp_is_err(m_axi.rresp);
                    w_rsp_valid_nxt = 1'b1;
                    w_rready_nxt    = 1'b0;
                    w_state_nxt     = ST_RSP;
                end
            end
            ST_WR: begin
                if (w_both_done) begin
                    w_bready_nxt = 1'b1;
                    w_state_nxt  = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (m_axi.bvalid && r_bready) begin
                    w_rsp_rdata_nxt = '0;
                    w_rsp_err_nxt   = resp_is_err(m_axi.bresp);
                    w_rsp_valid_nxt = 1'b1;
                    w_bready_nxt    = 1'b0;
                    w_state_nxt     = ST_RSP;
                end
            end
            ST_RSP: begin
                if (i_rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_timeout) begin
            w_arvalid_nxt   = 1'b0;
            w_rready_nxt    = 1'b0;
            w_bready_nxt    = 1'b0;
            w_abort         = 1'b1;
            w_rsp_rdata_nxt = '0;
            w_rsp_err_nxt   = 1'b1;
            w_rsp_valid_nxt = 1'b1;
            w_state_nxt     = ST_RSP;
        end
    end

    axi_lite_mst_wr_track u_wr_track (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_wr_start),
        .i_abort     (w_abort),
        .i_awready   (m_axi.awready),
        .i_wready    (m_axi.wready),
        .o_awvalid   (w_awvalid),
        .o_wvalid    (w_wvalid),
        .o_both_done (w_both_done)
    );

    assign m_axi.araddr  = r_araddr;
    assign m_axi.arvalid = r_arvalid;
    assign m_axi.rready  = r_rready;
    assign m_axi.awaddr  = r_awaddr;
    assign m_axi.awvalid = w_awvalid;
    assign m_axi.wdata   = r_wdata;
    assign m_axi.wstrb   = r_wstrb;
    assign m_axi.wvalid  = w_wvalid;
    assign m_axi.bready  = r_bready;

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;

endmodule
